// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS core memory-side arbitration logic.
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 28;
    localparam int unsigned LINE_W_DEFAULT = 128;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational winner select between I-cache and D-cache requests.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed D priority.
module arb_pick
    import mips_mem_pkg::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last_grant,
    output logic o_gnt_valid,
    output logic o_gnt_id
);

    always_comb begin
        o_gnt_valid = i_req_i | i_req_d;
`ifdef ARB_ROUND_ROBIN_EN
        // Contested grant goes to whichever requester was not served last.
        if (i_req_i && i_req_d) begin
            o_gnt_id = ~i_last_grant;
        end else begin
            o_gnt_id = i_req_d ? REQ_D : REQ_I;
        end
`else
        o_gnt_id = i_req_d ? REQ_D : REQ_I;
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic w_unused_last;
    assign w_unused_last = i_last_grant;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises I-cache and D-cache line requests onto one memory port.
// Arbitration policy selected by ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_bus_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned LINE_W = LINE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        r_state;
    logic              r_last_grant;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_i_ready;
    logic              r_d_ready;

    logic w_req_d;
    logic w_gnt_valid;
    logic w_gnt_id;

    assign w_req_d = d_read | d_write;

    arb_pick u_arb_pick (
        .i_req_i      (i_read),
        .i_req_d      (w_req_d),
        .i_last_grant (r_last_grant),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_id     (w_gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_I;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_ready    <= 1'b0;
            r_d_ready    <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_last_grant <= w_gnt_id;
                        if (w_gnt_id == REQ_D) begin
                            // A simultaneous read+write from the D-cache is a write-back.
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                            r_mem_write <= d_write;
                            r_mem_read  <= ~d_write;
                            r_state     <= BUSY_D;
                        end else begin
                            r_mem_addr  <= i_addr;
                            r_mem_read  <= 1'b1;
                            r_mem_write <= 1'b0;
                            r_state     <= BUSY_I;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        r_i_rdata   <= mem_rdata;
                        r_i_ready   <= 1'b1;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= DONE;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        if (r_mem_read) begin
                            r_d_rdata <= mem_rdata;
                        end
                        r_d_ready   <= 1'b1;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Requests still high here belong to the transaction just finished.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: which cache was served last, and the line each cache last received.
    logic          m_last;
    logic [LW-1:0] m_irdata;
    logic [LW-1:0] m_drdata;
    logic          grants[$];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // 1 = D-cache, 0 = I-cache
    function automatic logic model_pick(input logic want_i, input logic want_d);
        if (want_i && want_d) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (m_last == 1'b0) ? 1'b1 : 1'b0;
`else
            return 1'b1;
`endif
        end
        return want_d;
    endfunction

    task automatic quiet(input string tag);
        chk({tag, ".mem_read"},  mem_read,  1'b0);
        chk({tag, ".mem_write"}, mem_write, 1'b0);
        chk({tag, ".i_ready"},   i_ready,   1'b0);
        chk({tag, ".d_ready"},   d_ready,   1'b0);
        mem_ready = 1'($urandom % 2);
        mem_rdata = rand_line();
    endtask

    // Called at a negedge while the arbiter is idle with requests applied.
    // Returns at the negedge of the ready-pulse cycle with the winner's request dropped
    // (or, when stale is set, just after the following rising edge).
    task automatic serve(input int unsigned lat, input logic [LW-1:0] rd, input bit stale);
        logic          id;
        logic          wr;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        id = model_pick(i_read, d_read | d_write);
        m_last = id;
        wr = id & d_write;
        a  = id ? d_addr : i_addr;
        wd = d_wdata;
        for (int unsigned k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("busy.mem_read",  mem_read,  !wr);
            chk("busy.mem_write", mem_write, wr);
            chk("busy.mem_addr",  mem_addr,  a);
            if (wr) chk("busy.mem_wdata", mem_wdata, wd);
            chk("busy.i_ready", i_ready, 1'b0);
            chk("busy.d_ready", d_ready, 1'b0);
            mem_ready = (k == lat - 1);
            mem_rdata = (k == lat - 1) ? rd : rand_line();
        end
        @(negedge clk);
        mem_ready = 1'($urandom % 2);
        mem_rdata = rand_line();
        if (!id) m_irdata = rd;
        else if (!wr) m_drdata = rd;
        grants.push_back(d_ready);
        chk("done.i_ready",   i_ready,   !id);
        chk("done.d_ready",   d_ready,   id);
        chk("done.mem_read",  mem_read,  1'b0);
        chk("done.mem_write", mem_write, 1'b0);
        chk("done.i_rdata",   i_rdata,   m_irdata);
        chk("done.d_rdata",   d_rdata,   m_drdata);
        if (stale) begin
            @(posedge clk);
            #1;
        end
        if (id) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
    endtask

    initial begin
        logic exp_order [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.mem_read",  mem_read,  1'b0);
        chk("rst.mem_write", mem_write, 1'b0);
        chk("rst.i_ready",   i_ready,   1'b0);
        chk("rst.d_ready",   d_ready,   1'b0);
        chk("rst.mem_addr",  mem_addr,  '0);
        chk("rst.mem_wdata", mem_wdata, '0);
        chk("rst.i_rdata",   i_rdata,   '0);
        chk("rst.d_rdata",   d_rdata,   '0);
        rst = 1'b0;
        m_last = 1'b0; m_irdata = '0; m_drdata = '0;
        @(negedge clk);
        quiet("idle0");

        // Lone I-cache read, memory answers after three command cycles
        i_read = 1'b1; i_addr = 28'h0000010;
        serve(3, 128'hA5, 1'b0);
        @(negedge clk);
        quiet("iread.after");
        chk("iread.i_rdata", i_rdata, 128'hA5);

        // D-cache write-back leaves d_rdata untouched
        d_write = 1'b1; d_addr = 28'h0000020; d_wdata = 128'h1234;
        serve(2, rand_line(), 1'b0);
        @(negedge clk);
        quiet("dwr.after");
        chk("dwr.d_rdata", d_rdata, '0);

        // Contention three times in a row
        grants.delete();
        repeat (3) begin
            i_read = 1'b1; d_read = 1'b1;
            i_addr = AW'($urandom); d_addr = AW'($urandom);
            serve(1 + $urandom % 3, rand_line(), 1'b0);
            @(negedge clk);
            quiet("cont.gap");
            serve(1 + $urandom % 3, rand_line(), 1'b0);
            @(negedge clk);
            quiet("cont.after");
        end
        chk("cont.count", 128'(grants.size()), 128'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            chk($sformatf("cont.order%0d", i), grants[i], exp_order[i]);
        end

        // Stale request held through the ready cycle must not be re-issued
        d_read = 1'b1; d_addr = 28'h0000300;
        serve(2, rand_line(), 1'b1);
        @(negedge clk);
        quiet("stale.idle");
        @(negedge clk);
        quiet("stale.idle2");

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            int unsigned dsel;
            i_read = 1'($urandom % 2);
            dsel = $urandom % 4;
            d_read  = (dsel == 1) || (dsel == 3);
            d_write = (dsel == 2) || (dsel == 3);
            if (!i_read && dsel == 0) i_read = 1'b1;
            i_addr = AW'($urandom); d_addr = AW'($urandom); d_wdata = rand_line();
            serve(1 + $urandom % 4, rand_line(), 1'($urandom % 2));
            @(negedge clk);
            quiet("rnd.gap");
            if (i_read || d_read || d_write) begin
                serve(1 + $urandom % 4, rand_line(), 1'($urandom % 2));
                @(negedge clk);
                quiet("rnd.after");
            end
        end

        // Reset in the middle of a D-cache read
        mem_ready = 1'b0;
        d_read = 1'b1; d_addr = 28'h0000444;
        @(negedge clk);
        chk("mid.mem_read", mem_read, 1'b1);
        @(negedge clk);
        rst = 1'b1; d_read = 1'b0;
        @(negedge clk);
        chk("mid.mem_read",  mem_read,  1'b0);
        chk("mid.mem_write", mem_write, 1'b0);
        chk("mid.i_ready",   i_ready,   1'b0);
        chk("mid.d_ready",   d_ready,   1'b0);
        chk("mid.i_rdata",   i_rdata,   '0);
        chk("mid.d_rdata",   d_rdata,   '0);
        rst = 1'b0;
        m_last = 1'b0; m_irdata = '0; m_drdata = '0;
        @(negedge clk);
        quiet("mid.idle");
        @(negedge clk);
        quiet("mid.idle2");

        // mem_ready held high while idle, then a minimum-latency I-cache read
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("sus.i_ready",  i_ready,  1'b0);
            chk("sus.d_ready",  d_ready,  1'b0);
            chk("sus.mem_read", mem_read, 1'b0);
        end
        i_read = 1'b1; i_addr = 28'h0000555;
        serve(1, rand_line(), 1'b0);
        @(negedge clk);
        quiet("sus.after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
